// File: rtl/video_sig_decoder.sv
`timescale 1ns/1ps
// video_sig_decoder: capture-side timing recovery from hs/vs/ad -- coordinates, frame strobe/counter,
// measured totals and lock. Define VIDEO_SIG_DECODER_SYNC_MEAS_EN to also measure and lock on sync widths.
module video_sig_decoder #(
  parameter int MAX_H_PIXELS = 2048,
  parameter int MAX_LINES    = 1024,
  parameter int LOCK_FRAMES  = 2,
  localparam int HW = $clog2(MAX_H_PIXELS),
  localparam int VW = $clog2(MAX_LINES)
) (
  input  logic          clk_pixel_in,
  input  logic          rst_n_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          ad_in,
  output logic          de_out,
  output logic [HW-1:0] hcount_out,
  output logic [VW-1:0] vcount_out,
  output logic          nf_out,
  output logic [5:0]    fc_out,
  output logic [HW-1:0] h_total_out,
  output logic [HW-1:0] h_active_out,
  output logic [VW-1:0] v_total_out,
  output logic [VW-1:0] v_active_out,
`ifdef VIDEO_SIG_DECODER_SYNC_MEAS_EN
  output logic [HW-1:0] h_sync_out,
  output logic [VW-1:0] v_sync_out,
`endif
  output logic          locked_out,
  output logic          err_out
);

  localparam logic [HW-1:0] H_MAX  = '1;
  localparam logic [VW-1:0] V_MAX  = '1;
  localparam int            MW     = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_FRAMES);
`ifdef VIDEO_SIG_DECODER_SYNC_MEAS_EN
  localparam int CW = 3*HW + 3*VW;
`else
  localparam int CW = 2*HW + 2*VW;
`endif

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  state_t          r_state;
  logic [MW-1:0]   r_match_cnt;
  logic [CW-1:0]   r_ref;

  logic            r_hs_q, r_vs_q, r_ad_q;
  logic            w_hs_rise, w_vs_rise, w_ad_rise, w_ad_fall;

  logic [HW-1:0]   r_hpix, r_h_period, r_arun, r_line_active;
  logic            r_h_seen, r_a_seen;
  logic [VW-1:0]   r_lines;
  logic            r_frame_bad;

  logic [HW-1:0]   w_h_period;
  logic            w_period_bad, w_active_bad, w_sat, w_sync_bad, w_bad_now, w_frame_bad;
  logic [CW-1:0]   w_cap;
  logic            w_match;
  logic [MW-1:0]   w_match_next;

  assign w_hs_rise = hs_in & ~r_hs_q;
  assign w_vs_rise = vs_in & ~r_vs_q;
  assign w_ad_rise = ad_in & ~r_ad_q;
  assign w_ad_fall = ~ad_in & r_ad_q;

  // Input delay line and active-area coordinates (one cycle behind the inputs).
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hs_q     <= 1'b0;
      r_vs_q     <= 1'b0;
      r_ad_q     <= 1'b0;
      de_out     <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values, independent of statement order.
      r_hs_q <= hs_in;
      r_vs_q <= vs_in;
      r_ad_q <= ad_in;
      de_out <= ad_in;
      if (w_ad_rise)
        hcount_out <= '0;
      else if (ad_in && hcount_out != H_MAX)
        hcount_out <= hcount_out + 1'b1;
      if (w_vs_rise)
        vcount_out <= '0;
      else if (w_ad_fall && vcount_out != V_MAX)
        vcount_out <= vcount_out + 1'b1;
    end
  end

  assign w_h_period   = (r_hpix == H_MAX) ? H_MAX : r_hpix + 1'b1;
  assign w_period_bad = w_hs_rise & r_h_seen & (w_h_period != r_h_period);
  assign w_active_bad = w_ad_fall & r_a_seen & (r_arun != r_line_active);
  assign w_sat        = (r_hpix == H_MAX) | (r_arun == H_MAX) | (r_lines == V_MAX) |
                        (hcount_out == H_MAX) | (vcount_out == V_MAX);
  assign w_bad_now    = w_period_bad | w_active_bad | w_sat | w_sync_bad;
  assign w_frame_bad  = r_frame_bad | w_bad_now;

  // Line period, active width and line count, with within-frame consistency tracking.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hpix        <= '0;
      r_h_period    <= '0;
      r_h_seen      <= 1'b0;
      r_arun        <= '0;
      r_line_active <= '0;
      r_a_seen      <= 1'b0;
      r_lines       <= '0;
      r_frame_bad   <= 1'b0;
    end else begin
      if (w_hs_rise)
        r_hpix <= '0;
      else if (r_hpix != H_MAX)
        r_hpix <= r_hpix + 1'b1;

      if (w_hs_rise) begin
        r_h_period <= w_h_period;
        r_h_seen   <= 1'b1;
      end

      if (w_ad_rise)
        r_arun <= HW'(1);
      else if (ad_in && r_arun != H_MAX)
        r_arun <= r_arun + 1'b1;

      if (w_ad_fall) begin
        r_line_active <= r_arun;
        r_a_seen      <= 1'b1;
      end

      // The first line of each frame only seeds the comparison; it is never judged itself.
      if (w_vs_rise) begin
        r_lines     <= VW'(w_hs_rise);
        r_frame_bad <= 1'b0;
        r_h_seen    <= 1'b0;
        r_a_seen    <= 1'b0;
      end else begin
        if (w_hs_rise && r_lines != V_MAX)
          r_lines <= r_lines + 1'b1;
        if (w_bad_now)
          r_frame_bad <= 1'b1;
      end
    end
  end

`ifdef VIDEO_SIG_DECODER_SYNC_MEAS_EN
  logic [HW-1:0] r_hs_run;
  logic [VW-1:0] r_vs_hs;
  logic          r_s_seen;
  logic          w_hs_fall, w_vs_fall;

  assign w_hs_fall  = ~hs_in & r_hs_q;
  assign w_vs_fall  = ~vs_in & r_vs_q;
  assign w_sync_bad = (w_hs_fall & r_s_seen & (r_hs_run != h_sync_out)) |
                      (r_hs_run == H_MAX) | (r_vs_hs == V_MAX);

  // Sync pulse widths: hs in pixel clocks, vs in lines (hs rises seen while vs is high).
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hs_run   <= '0;
      r_vs_hs    <= '0;
      r_s_seen   <= 1'b0;
      h_sync_out <= '0;
      v_sync_out <= '0;
    end else begin
      if (w_hs_rise)
        r_hs_run <= HW'(1);
      else if (hs_in && r_hs_run != H_MAX)
        r_hs_run <= r_hs_run + 1'b1;

      if (w_hs_fall)
        h_sync_out <= r_hs_run;

      if (w_vs_rise)
        r_vs_hs <= VW'(w_hs_rise);
      else if (w_hs_rise && vs_in && r_vs_hs != V_MAX)
        r_vs_hs <= r_vs_hs + 1'b1;

      if (w_vs_fall)
        v_sync_out <= r_vs_hs;

      if (w_vs_rise)
        r_s_seen <= 1'b0;
      else if (w_hs_fall)
        r_s_seen <= 1'b1;
    end
  end

  assign w_cap = {r_h_period, r_line_active, r_lines, vcount_out, h_sync_out, v_sync_out};
`else
  assign w_sync_bad = 1'b0;
  assign w_cap      = {r_h_period, r_line_active, r_lines, vcount_out};
`endif

  assign w_match      = (w_cap == r_ref);
  assign w_match_next = r_match_cnt + 1'b1;

  // Lock FSM: every decision happens at a frame boundary (vs rise).
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= SEARCH;
      r_match_cnt  <= '0;
      r_ref        <= '0;
      nf_out       <= 1'b0;
      fc_out       <= '0;
      h_total_out  <= '0;
      h_active_out <= '0;
      v_total_out  <= '0;
      v_active_out <= '0;
      locked_out   <= 1'b0;
      err_out      <= 1'b0;
    end else begin
      nf_out  <= w_vs_rise;
      err_out <= 1'b0;
      if (w_vs_rise) begin
        fc_out <= (fc_out == 6'd59) ? 6'd0 : fc_out + 6'd1;
        case (r_state)
          SEARCH: r_state <= MEASURE;
          MEASURE: begin
            r_state     <= VERIFY;
            r_ref       <= w_cap;
            r_match_cnt <= '0;
          end
          VERIFY: begin
            r_ref        <= w_cap;
            h_total_out  <= r_h_period;
            h_active_out <= r_line_active;
            v_total_out  <= r_lines;
            v_active_out <= vcount_out;
            if (w_match && !w_frame_bad) begin
              if (w_match_next == LOCK_N) begin
                r_state     <= LOCKED;
                locked_out  <= 1'b1;
                r_match_cnt <= '0;
              end else begin
                r_match_cnt <= w_match_next;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end
          LOCKED: begin
            r_ref        <= w_cap;
            h_total_out  <= r_h_period;
            h_active_out <= r_line_active;
            v_total_out  <= r_lines;
            v_active_out <= vcount_out;
            if (!w_match || w_frame_bad) begin
              r_state     <= VERIFY;
              locked_out  <= 1'b0;
              err_out     <= 1'b1;
              r_match_cnt <= '0;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

endmodule
